// File: rtl/alu_exec_ctrl.sv
// Purpose: issue controller for the 8-bit ALU; holds the register file and the ACC/CB/EXT state.
// Latency: handshake at edge N, writeback at edge N+2, done high in the cycle after; 1 instr / 3 cycles.
// Backpressure: instr_ready is high only in IDLE. Optional macro ALU_EXEC_RETIRE_CNT_EN adds retire_cnt.
module alu_exec_ctrl #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [7:0]  instr,
    output logic        instr_ready,
    input  logic        reg_wr_en,
    input  logic [3:0]  reg_wr_addr,
    input  logic [7:0]  reg_wr_data,
    output logic [7:0]  alu_acc,
    output logic [7:0]  alu_ri,
    output logic [7:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_cb,
    input  logic [7:0]  alu_ext,
    output logic [7:0]  acc,
    output logic        cb,
    output logic [7:0]  ext,
`ifdef ALU_EXEC_RETIRE_CNT_EN
    output logic [15:0] retire_cnt,
`endif
    output logic        done,
    output logic        halted
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       instr_q;
    logic [7:0]       regs [NUM_REGS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] host_idx;
    logic [3:0]       cls;
    logic [3:0]       sub;
    logic             wr_acc;
    logic             wr_cb;
    logic             wr_ext;
    logic             mov_acc;
    logic             mov_reg;
    logic             is_hlt;
    logic             unused_bits;

    assign idx         = instr_q[IDX_W-1:0];
    assign host_idx    = reg_wr_addr[IDX_W-1:0];
    assign cls         = instr_q[7:4];
    assign sub         = instr_q[3:0];
    assign instr_ready = (state == ST_IDLE);
    assign halted      = (state == ST_HALT);
    assign alu_acc     = acc;
    // Index bits above the register-file depth are deliberately dropped.
    assign unused_bits = ^{reg_wr_addr, instr_q};

    // Writeback selection from the latched instruction class.
    always_comb begin
        wr_acc  = 1'b0;
        wr_cb   = 1'b0;
        wr_ext  = 1'b0;
        mov_acc = 1'b0;
        mov_reg = 1'b0;
        is_hlt  = 1'b0;
        case (cls)
            4'h0: begin
                if (sub >= 4'h1 && sub <= 4'h5) begin
                    wr_acc = 1'b1;
                end else if (sub == 4'h6 || sub == 4'h7) begin
                    wr_acc = 1'b1;
                    wr_cb  = 1'b1;
                end
            end
            4'h1, 4'h2: begin
                wr_acc = 1'b1;
                wr_cb  = 1'b1;
            end
            4'h3: begin
                wr_acc = 1'b1;
                wr_ext = 1'b1;
            end
            4'h5, 4'h6: wr_acc  = 1'b1;
            4'h7:       wr_cb   = 1'b1;
            4'h8:       mov_acc = 1'b1;
            4'h9:       mov_reg = 1'b1;
            4'hF:       is_hlt  = (sub == 4'hF);
            default: ;
        endcase
    end

    // Next-state logic: three-cycle issue loop, HALT is sticky until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = is_hlt ? ST_HALT : ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Datapath: instruction latch, register file, operand/opcode staging and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= 8'h00;
            alu_ri     <= 8'h00;
            alu_opcode <= 8'h00;
            acc        <= ACC_RESET;
            cb         <= 1'b0;
            ext        <= 8'h00;
            done       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (instr_valid) instr_q <= instr;
                if (reg_wr_en)   regs[host_idx] <= reg_wr_data;
            end
            if (state == ST_DECODE) begin
                alu_ri     <= regs[idx];
                // Register-to-ACC moves bypass the ALU, so it sees a NOP.
                alu_opcode <= (cls == 4'h8) ? 8'h00 : instr_q;
            end
            if (state == ST_EXEC) begin
                alu_opcode <= 8'h00;
                done       <= 1'b1;
                if (wr_acc)  acc <= alu_result;
                if (mov_acc) acc <= alu_ri;
                if (wr_cb)   cb  <= alu_cb;
                if (wr_ext)  ext <= alu_ext;
                if (mov_reg) regs[idx] <= acc;
            end
        end
    end

`ifdef ALU_EXEC_RETIRE_CNT_EN
    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)                   retire_cnt <= 16'h0000;
        else if (state == ST_EXEC) retire_cnt <= retire_cnt + 16'h0001;
    end
`endif
endmodule
